// File: rtl/flag_sync_pkg.sv
// Shared definitions for the flag arming path. Both the transmit and receive sides use
// the key pattern, the FSM encoding and the timer sizing helper.
package flag_sync_pkg;

  localparam logic [15:0] FLAG_KEY = 16'h12AB;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } arm_state_e;

  // The timer only ever holds 0 .. limit-1, so clog2 of the larger limit is enough.
  function automatic int timer_width(input int timeout, input int gap);
    int lim;
    lim = (timeout > gap) ? timeout : gap;
    return (lim < 2) ? 1 : $clog2(lim);
  endfunction

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

endpackage

// File: rtl/bit_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, clearing to 0 on reset.
module bit_sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/flag_arm_tx.sv
// Fires KEY toward the remote flag synchroniser, waits for the flag to come back and
// reports done/fail. Retries through a HOLD gap only when FLAG_ARM_RETRY_EN is defined.
module flag_arm_tx
  import flag_sync_pkg::*;
#(
  parameter logic [15:0] KEY       = FLAG_KEY,
  parameter int          TIMEOUT   = 64,
  parameter int          GAP       = 8
`ifdef FLAG_ARM_RETRY_EN
  ,
  parameter int          MAX_RETRY = 3
`endif
) (
  input  logic        sclk,
  input  logic        reset_n,
  input  logic        arm_req,
  input  logic        arm_abort,
  input  logic        flag_in,
  output logic [15:0] set_pulse,
  output logic        busy,
  output logic        flag_seen,
  output logic        arm_done,
  output logic        arm_fail,
  output logic [1:0]  retry_cnt,
  output logic [1:0]  dbg_state
);

  localparam int            TW           = timer_width(TIMEOUT, GAP);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
`ifdef FLAG_ARM_RETRY_EN
  localparam logic [TW-1:0] GAP_LAST     = TW'(GAP - 1);
  localparam int            RW           = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_LAST   = RW'(MAX_RETRY);
`endif

  // Request handshake: arm_req is a single-cycle valid with no ready. It is taken only
  // in IDLE when arm_abort is low; at any other time it is dropped and busy=1 tells the
  // requester so. The operation always ends in exactly one arm_done, one arm_fail, or
  // (on abort) neither.

  arm_state_e    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   set_pulse_q, set_pulse_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          fail_q, fail_d;
  logic [1:0]    retry_cnt_q, retry_cnt_d;
`ifdef FLAG_ARM_RETRY_EN
  logic [RW-1:0] extra_q, extra_d;
`endif

  logic fire;
  logic accept;
  logic done_ev;
  logic fail_ev;

  bit_sync_2ff u_flag_sync (
    .clk   (sclk),
    .rst_n (reset_n),
    .d     (flag_in),
    .q     (flag_seen)
  );

  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      set_pulse_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      retry_cnt_q <= 2'd0;
`ifdef FLAG_ARM_RETRY_EN
      extra_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      set_pulse_q <= set_pulse_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      retry_cnt_q <= retry_cnt_d;
`ifdef FLAG_ARM_RETRY_EN
      extra_q     <= extra_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    fire    = 1'b0;
    accept  = 1'b0;
    done_ev = 1'b0;
    fail_ev = 1'b0;
`ifdef FLAG_ARM_RETRY_EN
    extra_d = extra_q;
`endif
    if (arm_abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm_req) begin
            accept = 1'b1;
`ifdef FLAG_ARM_RETRY_EN
            extra_d = '0;
`endif
            // Flag already up: nothing to send, report success straight away.
            if (flag_seen) begin
              done_ev = 1'b1;
            end else begin
              fire    = 1'b1;
              state_d = ST_FIRE;
            end
          end
        end
        ST_FIRE: begin
          timer_d = '0;
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (flag_seen) begin
            done_ev = 1'b1;
            state_d = ST_IDLE;
          end else if (timer_q == TIMEOUT_LAST) begin
`ifdef FLAG_ARM_RETRY_EN
            if (extra_q < RETRY_LAST) begin
              timer_d = '0;
              state_d = ST_HOLD;
            end else begin
              fail_ev = 1'b1;
              state_d = ST_IDLE;
            end
`else
            fail_ev = 1'b1;
            state_d = ST_IDLE;
`endif
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
`ifdef FLAG_ARM_RETRY_EN
        ST_HOLD: begin
          if (flag_seen) begin
            done_ev = 1'b1;
            state_d = ST_IDLE;
          end else if (timer_q == GAP_LAST) begin
            fire    = 1'b1;
            extra_d = extra_q + 1'b1;
            state_d = ST_FIRE;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    set_pulse_d = fire ? KEY : '0;
    busy_d      = (state_d != ST_IDLE);
    done_d      = done_ev;
    fail_d      = fail_ev;
    if (accept) begin
      retry_cnt_d = fire ? 2'd1 : 2'd0;
    end else if (fire) begin
      retry_cnt_d = sat_inc2(retry_cnt_q);
    end else begin
      retry_cnt_d = retry_cnt_q;
    end
  end

  // An abort that lands in the FIRE cycle must not let the key escape, so the
  // registered pulse is gated by the live abort input.
  assign set_pulse = arm_abort ? 16'h0000 : set_pulse_q;
  assign busy      = busy_q;
  assign arm_done  = done_q;
  assign arm_fail  = fail_q;
  assign retry_cnt = retry_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_flag_arm_tx.sv
// Directed bench for flag_arm_tx: a per-cycle vector table plus multi-cycle sequences
// for abort, asynchronous reset, timeout/retry and flag-vs-timeout races.
module tb_flag_arm_tx;

  localparam logic [15:0] KEY     = 16'h12AB;
  localparam int          TIMEOUT = 64;
  localparam int          GAP     = 8;
  localparam int          PERIOD  = TIMEOUT + GAP + 1;
`ifdef FLAG_ARM_RETRY_EN
  localparam int          MAX_RETRY = 3;
`endif
  localparam logic [1:0]  S_IDLE = 2'd0;
  localparam logic [1:0]  S_FIRE = 2'd1;
  localparam logic [1:0]  S_WAIT = 2'd2;

  logic        sclk;
  logic        reset_n;
  logic        arm_req;
  logic        arm_abort;
  logic        flag_in;
  logic [15:0] set_pulse;
  logic        busy;
  logic        flag_seen;
  logic        arm_done;
  logic        arm_fail;
  logic [1:0]  retry_cnt;
  logic [1:0]  dbg_state;

  int n_chk;
  int n_pass;
  logic [15:0] exp_q[$];

  typedef struct packed {
    logic        req;
    logic        abort;
    logic        flag;
    logic [15:0] pulse;
    logic        busy;
    logic        seen;
    logic        done;
    logic        fail;
    logic [1:0]  rc;
    logic [1:0]  st;
  } vec_t;

  vec_t vq[$];

  flag_arm_tx #(
    .KEY       (KEY),
    .TIMEOUT   (TIMEOUT),
    .GAP       (GAP)
`ifdef FLAG_ARM_RETRY_EN
    ,
    .MAX_RETRY (MAX_RETRY)
`endif
  ) dut (
    .sclk      (sclk),
    .reset_n   (reset_n),
    .arm_req   (arm_req),
    .arm_abort (arm_abort),
    .flag_in   (flag_in),
    .set_pulse (set_pulse),
    .busy      (busy),
    .flag_seen (flag_seen),
    .arm_done  (arm_done),
    .arm_fail  (arm_fail),
    .retry_cnt (retry_cnt),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic add(input logic req, input logic abort, input logic flag,
                     input logic [15:0] pulse, input logic bsy, input logic seen,
                     input logic done, input logic fail, input logic [1:0] rc,
                     input logic [1:0] st);
    vec_t v;
    v = '{req, abort, flag, pulse, bsy, seen, done, fail, rc, st};
    vq.push_back(v);
  endtask

  function automatic logic [23:0] outs();
    return {set_pulse, busy, flag_seen, arm_done, arm_fail, retry_cnt, dbg_state};
  endfunction

  // One full operation: fires arm_req, watches a fixed window, compares against a
  // model built from TIMEOUT/GAP/PERIOD arithmetic.
  task automatic run_attempt(input string name, input int flag_at, input int n_pulses,
                             input int exp_done_at, input int exp_fail_at,
                             input logic [1:0] exp_rc);
    logic [15:0] got_q[$];
    int done_n, fail_n, done_at, fail_at, busy_err, bad_key, both_hi, exp_end;
    exp_q.delete();
    for (int i = 0; i < n_pulses; i++) exp_q.push_back(16'(i * PERIOD));
    exp_end  = (exp_done_at >= 0) ? exp_done_at : exp_fail_at;
    done_n   = 0;
    fail_n   = 0;
    done_at  = -1;
    fail_at  = -1;
    busy_err = 0;
    bad_key  = 0;
    both_hi  = 0;
    arm_req = 1'b1;
    step();
    arm_req = 1'b0;
    for (int off = 0; off <= exp_end + 4; off++) begin
      if (set_pulse != 16'h0000) begin
        got_q.push_back(16'(off));
        if (set_pulse != KEY) bad_key++;
      end
      if (arm_done) begin
        done_n++;
        done_at = off;
      end
      if (arm_fail) begin
        fail_n++;
        fail_at = off;
      end
      if (arm_done && arm_fail) both_hi++;
      if (busy != (off < exp_end)) busy_err++;
      if (off == flag_at) flag_in = 1'b1;
      step();
    end
    chk({name, "_pulse_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({name, "_pulse_at"}, got_q[i], exp_q[i]);
    chk({name, "_done_count"}, done_n, (exp_done_at >= 0) ? 1 : 0);
    chk({name, "_fail_count"}, fail_n, (exp_fail_at >= 0) ? 1 : 0);
    chk({name, "_done_at"}, done_at, exp_done_at);
    chk({name, "_fail_at"}, fail_at, exp_fail_at);
    chk({name, "_busy_errors"}, busy_err, 0);
    chk({name, "_bad_key"}, bad_key, 0);
    chk({name, "_done_and_fail"}, both_hi, 0);
    chk({name, "_retry_cnt"}, retry_cnt, exp_rc);
    flag_in = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    reset_n   = 1'b0;
    arm_req   = 1'b0;
    arm_abort = 1'b0;
    flag_in   = 1'b0;

    //   req abort flag  pulse     busy seen done fail rc    state
    add(0, 0, 0, 16'h0000, 0, 0, 0, 0, 2'd0, S_IDLE);
    add(1, 0, 0, KEY,      1, 0, 0, 0, 2'd1, S_FIRE);
    add(0, 0, 0, 16'h0000, 1, 0, 0, 0, 2'd1, S_WAIT);
    add(0, 0, 0, 16'h0000, 1, 0, 0, 0, 2'd1, S_WAIT);
    add(0, 0, 0, 16'h0000, 1, 0, 0, 0, 2'd1, S_WAIT);
    add(0, 0, 0, 16'h0000, 1, 0, 0, 0, 2'd1, S_WAIT);
    add(0, 0, 1, 16'h0000, 1, 0, 0, 0, 2'd1, S_WAIT);
    add(0, 0, 1, 16'h0000, 1, 1, 0, 0, 2'd1, S_WAIT);
    add(0, 0, 1, 16'h0000, 0, 1, 1, 0, 2'd1, S_IDLE);
    add(0, 0, 1, 16'h0000, 0, 1, 0, 0, 2'd1, S_IDLE);
    add(1, 0, 1, 16'h0000, 0, 1, 1, 0, 2'd0, S_IDLE);
    add(0, 0, 0, 16'h0000, 0, 1, 0, 0, 2'd0, S_IDLE);
    add(0, 0, 0, 16'h0000, 0, 0, 0, 0, 2'd0, S_IDLE);
    add(1, 0, 0, KEY,      1, 0, 0, 0, 2'd1, S_FIRE);
    add(1, 0, 0, 16'h0000, 1, 0, 0, 0, 2'd1, S_WAIT);
    add(1, 0, 0, 16'h0000, 1, 0, 0, 0, 2'd1, S_WAIT);
    add(0, 1, 0, 16'h0000, 0, 0, 0, 0, 2'd1, S_IDLE);
    add(1, 1, 0, 16'h0000, 0, 0, 0, 0, 2'd1, S_IDLE);
    add(0, 0, 0, 16'h0000, 0, 0, 0, 0, 2'd1, S_IDLE);

    repeat (3) step();
    chk("reset_outputs", outs(), 24'h0);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < vq.size(); i++) begin
      arm_req   = vq[i].req;
      arm_abort = vq[i].abort;
      flag_in   = vq[i].flag;
      step();
      chk($sformatf("vec%0d", i), outs(),
          {vq[i].pulse, vq[i].busy, vq[i].seen, vq[i].done, vq[i].fail, vq[i].rc, vq[i].st});
    end
    arm_req   = 1'b0;
    arm_abort = 1'b0;
    flag_in   = 1'b0;
    step();

    // abort landing in the FIRE cycle
    arm_req = 1'b1;
    step();
    arm_req = 1'b0;
    chk("abort_fire_pre", set_pulse, KEY);
    arm_abort = 1'b1;
    #1;
    chk("abort_fire_pulse", set_pulse, 16'h0000);
    step();
    arm_abort = 1'b0;
    chk("abort_fire_next", {set_pulse, busy, arm_done, arm_fail, dbg_state},
        {16'h0000, 1'b0, 1'b0, 1'b0, S_IDLE});
    step();
    chk("abort_fire_quiet", {set_pulse, busy, arm_done, arm_fail}, 19'h0);

    // asynchronous reset while the key is on the wire
    arm_req = 1'b1;
    step();
    arm_req = 1'b0;
    reset_n = 1'b0;
    #2;
    chk("rst_fire_pulse", set_pulse, 16'h0000);
    step();
    reset_n = 1'b1;
    step();

    // asynchronous reset in WAIT, then a normal re-arm
    arm_req = 1'b1;
    step();
    arm_req = 1'b0;
    step();
    step();
    chk("rst_wait_pre", {busy, retry_cnt, dbg_state}, {1'b1, 2'd1, S_WAIT});
    reset_n = 1'b0;
    #2;
    chk("rst_wait_outputs", outs(), 24'h0);
    step();
    reset_n = 1'b1;
    step();
    arm_req = 1'b1;
    step();
    arm_req = 1'b0;
    chk("rearm_after_reset", {set_pulse, busy, retry_cnt, dbg_state},
        {KEY, 1'b1, 2'd1, S_FIRE});
    arm_abort = 1'b1;
    step();
    arm_abort = 1'b0;
    step();

`ifdef FLAG_ARM_RETRY_EN
    run_attempt("all_timeout", -1, 1 + MAX_RETRY, -1, MAX_RETRY * PERIOD + TIMEOUT + 1, 2'd3);
    run_attempt("flag_in_hold", PERIOD + TIMEOUT + 1, 2, PERIOD + TIMEOUT + 4, -1, 2'd2);
`else
    run_attempt("single_timeout", -1, 1, -1, TIMEOUT + 1, 2'd1);
`endif
    run_attempt("flag_at_timeout", TIMEOUT - 2, 1, TIMEOUT + 1, -1, 2'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
